// File: rtl/tc_sample_sched_if.sv
// Handshake bundle between the scheduler, the ADC SPI master and the thermocouple calculator.
interface tc_sample_sched_if #(
   parameter int unsigned WORD_SIZE = 16
);
   logic                 o_adc_start;
   logic [9:0]           i_adc_word;
   logic                 i_adc_stb;
   logic                 o_calc_start;
   logic [9:0]           o_calc_code;
   logic [WORD_SIZE-1:0] i_calc_temp;
   logic                 i_calc_done;

   modport master (
      output o_adc_start, o_calc_start, o_calc_code,
      input  i_adc_word, i_adc_stb, i_calc_temp, i_calc_done
   );

   modport slave (
      input  o_adc_start, o_calc_start, o_calc_code,
      output i_adc_word, i_adc_stb, i_calc_temp, i_calc_done
   );
endinterface

// File: rtl/tc_sample_sched.sv
// Conversion scheduler: periodic ADC bursts averaged over 1/2/4/8 codes, one calculation per
// burst, latest-temperature hold, sticky timeout and overrun flags.
module tc_sample_sched #(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_ena,
   input  logic [CNT_W-1:0]     i_interval,
   input  logic [1:0]           i_avg_log2,
   input  logic                 i_err_clr,
   tc_sample_sched_if.master    io_bus,
   output logic [WORD_SIZE-1:0] o_temp,
   output logic                 o_temp_valid,
   output logic                 o_timeout,
   output logic                 o_overrun
);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ADC_WAIT  = 2'd1;
   localparam logic [1:0] ST_CALC_WAIT = 2'd2;

   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [1:0]           r_state, w_state_nxt;
   logic [12:0]          r_acc, w_acc_nxt;
   logic [3:0]           r_nsamp, w_nsamp_nxt;
   logic [TMO_W-1:0]     r_tmo, w_tmo_nxt;
   logic [1:0]           r_avg, w_avg_nxt;
   logic                 r_adc_start, w_adc_start_nxt;
   logic                 r_calc_start, w_calc_start_nxt;
   logic [9:0]           r_calc_code, w_calc_code_nxt;
   logic [WORD_SIZE-1:0] r_temp, w_temp_nxt;
   logic                 r_temp_valid, w_temp_valid_nxt;
   logic                 r_timeout, r_overrun;
   logic                 w_tick, w_tmo_hit, w_burst_done, w_timeout_set, w_overrun_set;
   logic [12:0]          w_sum;
   logic [3:0]           w_nsamp_inc;

   assign w_tick        = i_ena && (r_cnt == '0);
   // 13-bit accumulator holds 8 x 0x3FF without wrapping
   assign w_sum         = r_acc + 13'(io_bus.i_adc_word);
   assign w_nsamp_inc   = r_nsamp + 4'd1;
   assign w_burst_done  = (w_nsamp_inc == (4'd1 << r_avg));
   assign w_tmo_hit     = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
   assign w_overrun_set = w_tick && (r_state != ST_IDLE);

   always_comb begin
      w_cnt_nxt         = r_cnt;
      w_state_nxt       = r_state;
      w_acc_nxt         = r_acc;
      w_nsamp_nxt       = r_nsamp;
      w_tmo_nxt         = r_tmo;
      w_avg_nxt         = r_avg;
      w_adc_start_nxt   = 1'b0;
      w_calc_start_nxt  = 1'b0;
      w_calc_code_nxt   = r_calc_code;
      w_temp_nxt        = r_temp;
      w_temp_valid_nxt  = r_temp_valid;
      w_timeout_set     = 1'b0;

      if (!i_ena) begin
         w_cnt_nxt   = '0;
         w_state_nxt = ST_IDLE;
         w_acc_nxt   = '0;
         w_nsamp_nxt = '0;
         w_tmo_nxt   = '0;
      end else begin
         w_cnt_nxt = (r_cnt == '0) ? i_interval : r_cnt - 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_tick) begin
                  w_adc_start_nxt = 1'b1;
                  w_acc_nxt       = '0;
                  w_nsamp_nxt     = '0;
                  w_tmo_nxt       = '0;
                  w_avg_nxt       = i_avg_log2;
                  w_state_nxt     = ST_ADC_WAIT;
               end
            end
            ST_ADC_WAIT: begin
               // a strobe on the timeout cycle still counts as a sample
               if (io_bus.i_adc_stb) begin
                  w_acc_nxt   = w_sum;
                  w_nsamp_nxt = w_nsamp_inc;
                  w_tmo_nxt   = '0;
                  if (w_burst_done) begin
                     w_calc_code_nxt  = 10'(w_sum >> r_avg);
                     w_calc_start_nxt = 1'b1;
                     w_state_nxt      = ST_CALC_WAIT;
                  end else begin
                     w_adc_start_nxt = 1'b1;
                  end
               end else if (w_tmo_hit) begin
                  w_timeout_set = 1'b1;
                  w_tmo_nxt     = '0;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_tmo_nxt = r_tmo + 1'b1;
               end
            end
            ST_CALC_WAIT: begin
               if (io_bus.i_calc_done) begin
                  w_temp_nxt       = io_bus.i_calc_temp;
                  w_temp_valid_nxt = 1'b1;
                  w_tmo_nxt        = '0;
                  w_state_nxt      = ST_IDLE;
               end else if (w_tmo_hit) begin
                  w_timeout_set = 1'b1;
                  w_tmo_nxt     = '0;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_tmo_nxt = r_tmo + 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt        <= '0;
         r_state      <= ST_IDLE;
         r_acc        <= '0;
         r_nsamp      <= '0;
         r_tmo        <= '0;
         r_avg        <= '0;
         r_adc_start  <= 1'b0;
         r_calc_start <= 1'b0;
         r_calc_code  <= '0;
         r_temp       <= '0;
         r_temp_valid <= 1'b0;
         r_timeout    <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_nsamp      <= w_nsamp_nxt;
         r_tmo        <= w_tmo_nxt;
         r_avg        <= w_avg_nxt;
         r_adc_start  <= w_adc_start_nxt;
         r_calc_start <= w_calc_start_nxt;
         r_calc_code  <= w_calc_code_nxt;
         r_temp       <= w_temp_nxt;
         r_temp_valid <= w_temp_valid_nxt;
         // a new error in the same cycle as a clear wins
         r_timeout    <= w_timeout_set | (r_timeout & ~i_err_clr);
         r_overrun    <= w_overrun_set | (r_overrun & ~i_err_clr);
      end
   end

   assign io_bus.o_adc_start  = r_adc_start;
   assign io_bus.o_calc_start = r_calc_start;
   assign io_bus.o_calc_code  = r_calc_code;
   assign o_temp              = r_temp;
   assign o_temp_valid        = r_temp_valid;
   assign o_timeout           = r_timeout;
   assign o_overrun           = r_overrun;
endmodule
